// File: rtl/t_ff_pkg.sv
// t_ff_pkg: shared constants and helpers for the toggle flip-flop bank.
// Optional feature macro used by this block: T_FF_TOGGLE_CNT_EN.
package t_ff_pkg;

   localparam int T_FF_DEFAULT_WIDTH = 1;
   localparam int T_FF_DEFAULT_CNT_W = 16;

   // Saturating increment of a counter that is 'width' bits wide (width <= 32).
   // The value is carried in a 32-bit container; bits above 'width' stay zero.
   function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
      logic [31:0] max_val;
      max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      return (value >= max_val) ? max_val : value + 32'd1;
   endfunction

endpackage

// File: rtl/t_ff_if.sv
// t_ff_if: toggle request / state bundle for the t_ff bank.
// toggle_cnt exists only when T_FF_TOGGLE_CNT_EN is defined.
// There is no handshake: t is sampled on every rising clk edge and q is a
// plain registered value that is valid on every cycle after the first reset.
interface t_ff_if
   import t_ff_pkg::*;
#(
   parameter int WIDTH = T_FF_DEFAULT_WIDTH,
   parameter int CNT_W = T_FF_DEFAULT_CNT_W
);

   logic [WIDTH-1:0] t;
   logic [WIDTH-1:0] q;
`ifdef T_FF_TOGGLE_CNT_EN
   logic [CNT_W-1:0] toggle_cnt;

   modport master (output t, input q, input toggle_cnt);
   modport slave  (input t, output q, output toggle_cnt);
`else
   modport master (output t, input q);
   modport slave  (input t, output q);
`endif

endinterface

// File: rtl/t_ff_bit.sv
// t_ff_bit: single-bit toggle cell. Reset loads rst_val and dominates t.
module t_ff_bit (
   input  logic clk,
   input  logic reset,
   input  logic rst_val,
   input  logic t,
   output logic q
);

   // Toggle on t, hold otherwise; reset wins so q is known after any reset edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         q <= rst_val;
      end else begin
         q <= q ^ t;
      end
   end

endmodule

// File: rtl/t_ff.sv
// t_ff: bank of WIDTH independent toggle flip-flops.
// Define T_FF_TOGGLE_CNT_EN to add a saturating counter of bit-0 toggles.
// The interface instance must be built with the same WIDTH/CNT_W values.
module t_ff
   import t_ff_pkg::*;
#(
   parameter int               WIDTH       = T_FF_DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int               CNT_W       = T_FF_DEFAULT_CNT_W
) (
   input logic   clk,
   input logic   reset,
   t_ff_if.slave bus
);

   logic [WIDTH-1:0] t_vec;
   logic [WIDTH-1:0] q_vec;

   assign t_vec  = bus.t;
   assign bus.q  = q_vec;

   // One cell per bit; bits never interact.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      t_ff_bit u_bit (
         .clk     (clk),
         .reset   (reset),
         .rst_val (RESET_VALUE[i]),
         .t       (t_vec[i]),
         .q       (q_vec[i])
      );
   end

`ifdef T_FF_TOGGLE_CNT_EN
   logic [CNT_W-1:0] cnt;
   logic [31:0]      cnt_next;

   assign cnt_next       = sat_inc(32'(cnt), CNT_W);
   assign bus.toggle_cnt = cnt;

   // Count edges where bit 0 toggles; stick at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (t_vec[0]) begin
         cnt <= cnt_next[CNT_W-1:0];
      end
   end

   // Upper container bits of the helper result are always zero.
   if (CNT_W < 32) begin : g_cnt_hi
      logic unused_cnt_hi;
      assign unused_cnt_hi = |cnt_next[31:CNT_W];
   end
`endif

endmodule

// File: tb/tb_t_ff.sv
// tb_t_ff: directed test-plan sequences followed by randomized stimulus on a
// 1-bit bank and a 4-bit bank (RESET_VALUE=4'b1010), with CNT_W=2 so the
// optional toggle counter (T_FF_TOGGLE_CNT_EN) reaches saturation quickly.
`timescale 1ns/1ps
module tb_t_ff;
   import t_ff_pkg::*;

   localparam int         CNT_W   = 2;
   localparam int         CNT_MAX = (1 << CNT_W) - 1;
   localparam logic       RV1     = 1'b0;
   localparam logic [3:0] RV4     = 4'b1010;
   localparam int         W       = 1 + 4 + CNT_W;

   logic clk;
   logic reset;

   t_ff_if #(.WIDTH(1), .CNT_W(CNT_W)) bus1 ();
   t_ff_if #(.WIDTH(4), .CNT_W(CNT_W)) bus4 ();

   t_ff #(.WIDTH(1), .RESET_VALUE(RV1), .CNT_W(CNT_W)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1)
   );

   t_ff #(.WIDTH(4), .RESET_VALUE(RV4), .CNT_W(CNT_W)) dut4 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus4)
   );

   int checks   = 0;
   int failures = 0;

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      #30;
      forever begin
         clk = 1'b1;
         #60;
         clk = 1'b0;
         #60;
      end
   end

   // ---------------- shared compare helper ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] dut_cnt();
`ifdef T_FF_TOGGLE_CNT_EN
      return 32'(bus1.toggle_cnt);
`else
      return 32'd0;
`endif
   endfunction

   // ---------------- behavioural model + scoreboard ----------------
   // q[i] = RESET_VALUE[i] xor parity(number of t[i]=1 edges since last reset);
   // toggle_cnt = min(number of t[0]=1 edges since last reset, all-ones).
   logic [W-1:0] exp_q[$];
   bit           model_valid = 1'b0;
   int           ones1       = 0;
   int           ones4[4]    = '{0, 0, 0, 0};

   initial begin
      logic         r;
      logic         a;
      logic [3:0]   b;
      logic [3:0]   e4;
      logic [W-1:0] e;
      logic [W-1:0] got;
      forever begin
         @(posedge clk);
         r = reset;
         a = bus1.t;
         b = bus4.t;
         if (r === 1'b1) begin
            model_valid = 1'b1;
            ones1 = 0;
            for (int i = 0; i < 4; i++) ones4[i] = 0;
         end else if (model_valid) begin
            if (a === 1'b1) ones1++;
            for (int i = 0; i < 4; i++) if (b[i] === 1'b1) ones4[i]++;
         end
         if (model_valid) begin
            for (int i = 0; i < 4; i++) e4[i] = RV4[i] ^ ones4[i][0];
            e = {RV1 ^ ones1[0], e4, CNT_W'((ones1 > CNT_MAX) ? CNT_MAX : ones1)};
            exp_q.push_back(e);
         end
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = {bus1.q, bus4.q, CNT_W'(dut_cnt())};
            check("q1_model", 32'(got[W-1]), 32'(e[W-1]));
            check("q4_model", 32'(got[W-2 -: 4]), 32'(e[W-2 -: 4]));
`ifdef T_FF_TOGGLE_CNT_EN
            check("cnt_model", 32'(got[CNT_W-1:0]), 32'(e[CNT_W-1:0]));
`endif
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic next_edge();
      @(posedge clk);
      #10;
   endtask

   task automatic pin(input string tag, input logic q1, input logic [3:0] q4, input int cnt);
      check({tag, "_q1"}, 32'(bus1.q), 32'(q1));
      check({tag, "_q4"}, 32'(bus4.q), 32'(q4));
`ifdef T_FF_TOGGLE_CNT_EN
      check({tag, "_cnt"}, dut_cnt(), 32'(cnt));
`else
      if (cnt < 0) check({tag, "_cnt_arg"}, 32'(cnt), 32'd0);
`endif
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset  = 1'b1;
      bus1.t = 1'bx;
      bus4.t = 4'bxxxx;

      // Reset with t undriven.
      next_edge();                       // edge 30
      pin("reset_tx", 1'b0, 4'b1010, 0);
      #60;                               // 100 ns
      reset  = 1'b0;
      bus1.t = 1'b0;
      bus4.t = 4'b0000;

      // Hold.
      next_edge();                       // edge 150
      pin("hold", 1'b0, 4'b1010, 0);
      #40;                               // 200 ns
      bus1.t = 1'b1;
      bus4.t = 4'b0101;

      // Toggle at clk/2; 4-bit bank alternates 1111/1010.
      next_edge();                       // edge 270
      pin("tog_270", 1'b1, 4'b1111, 1);
      next_edge();                       // edge 390
      pin("tog_390", 1'b0, 4'b1010, 2);
      next_edge();                       // edge 510
      pin("tog_510", 1'b1, 4'b1111, 3);

      // Reset pulse mid-toggle overrides that edge's toggle.
      reset = 1'b1;
      next_edge();                       // edge 630
      pin("mid_rst", 1'b0, 4'b1010, 0);
      reset = 1'b0;

      // Five toggles after reset: counter 1,2,3,3,3.
      next_edge();
      pin("run1", 1'b1, 4'b1111, 1);
      next_edge();
      pin("run2", 1'b0, 4'b1010, 2);
      next_edge();
      pin("run3", 1'b1, 4'b1111, 3);
      next_edge();
      pin("run4", 1'b0, 4'b1010, 3);
      next_edge();
      pin("run5", 1'b1, 4'b1111, 3);
      reset = 1'b1;
      next_edge();
      pin("rst_clr", 1'b0, 4'b1010, 0);
      reset = 1'b0;

      // Randomized traffic with occasional resets.
      for (int n = 0; n < 300; n++) begin
         reset  = ($urandom_range(0, 19) == 0);
         bus1.t = ($urandom_range(0, 3) != 0);
         bus4.t = 4'($urandom_range(0, 15));
         next_edge();
      end

      next_edge();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
